// File: rtl/x86_prefetch_pkg.sv
// Shared constants and helpers for the x86 front end: prefetch defaults,
// the fetch pipeline flag bundle and the segment:offset linear-address function.
package x86_pkg;

    localparam int          DEF_DEPTH    = 8;
    localparam logic [15:0] DEF_RESET_CS = 16'hFFFF;
    localparam logic [15:0] DEF_RESET_IP = 16'h0000;

    // rd: request on the bus now; cap: its byte arrives this cycle; drop: discard that byte
    typedef struct packed {
        logic rd;
        logic cap;
        logic drop;
    } fetch_pipe_t;

    // 20-bit real-mode address; the carry out of bit 19 is discarded (FFFF:0010 -> 00000)
    function automatic logic [19:0] linear_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/x86_prefetch_fifo.sv
// DEPTH x 8 circular byte buffer with clear; the head byte is held in a register
// that is refreshed every edge so it is valid together with a nonzero count.
module prefetch_fifo
    import x86_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          do_rd, do_wr;

    assign do_rd = rd_en & ~clear & (count_q != '0);
    assign do_wr = wr_en & ~clear & ((count_q != FULL_CNT) | do_rd);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (clear) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            rd_data_d = 8'h00;
        end else begin
            if (do_wr)
                tail_d = tail_q + 1'b1;
            if (do_rd)
                head_d = head_q + 1'b1;
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            // the new head may be the very entry being written on this edge
            if (do_wr && (tail_q == head_d))
                rd_data_d = wr_data;
            else
                rd_data_d = mem[head_d];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr)
            mem[tail_q] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign valid   = (count_q != '0);

endmodule

// File: rtl/x86_prefetch.sv
// Instruction prefetch queue: issues one-byte code fetches at cs:ip while the bus is
// granted, buffers them, and presents the head byte with its IP to the decoder.
module x86_prefetch
    import x86_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [15:0] RESET_CS = DEF_RESET_CS,
    parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     locked,
    input  logic                     flush,
    input  logic [15:0]              new_cs,
    input  logic [15:0]              new_ip,
    input  logic                     bus_grant,
    output logic [19:0]              address,
    output logic                     rd,
    input  logic [7:0]               i_data,
    output logic [7:0]               q_byte,
    output logic                     q_valid,
    input  logic                     q_take,
    output logic [15:0]              q_ip,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [15:0] fetch_cs_q, fetch_cs_d;
    logic [15:0] fetch_ip_q, fetch_ip_d;
    logic [15:0] q_ip_q, q_ip_d;
    logic [19:0] address_q, address_d;
    fetch_pipe_t pipe_q, pipe_d;
    logic        take_fire, capture, issue;
    logic [CW:0] pending;

    assign take_fire = q_take & q_valid & locked & ~flush;
    assign capture   = pipe_q.cap & ~pipe_q.drop & ~flush;
    // reserve room for both the request on the bus and the byte arriving now
    assign pending   = (CW+1)'(q_count) + (CW+1)'(pipe_q.rd) + (CW+1)'(pipe_q.cap & ~pipe_q.drop);
    assign issue     = locked & bus_grant & ~flush & (pending < DEPTH_W);

    always_comb begin
        fetch_cs_d  = fetch_cs_q;
        fetch_ip_d  = fetch_ip_q;
        q_ip_d      = q_ip_q;
        address_d   = address_q;
        pipe_d.rd   = issue;
        pipe_d.cap  = pipe_q.rd;
        pipe_d.drop = 1'b0;
        if (flush) begin
            fetch_cs_d  = new_cs;
            fetch_ip_d  = new_ip;
            q_ip_d      = new_ip;
            address_d   = linear_addr(new_cs, new_ip);
            pipe_d.drop = pipe_q.rd;
        end else begin
            if (issue) begin
                address_d  = linear_addr(fetch_cs_q, fetch_ip_q);
                fetch_ip_d = fetch_ip_q + 16'd1;
            end
            if (take_fire)
                q_ip_d = q_ip_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            q_ip_q     <= RESET_IP;
            address_q  <= linear_addr(RESET_CS, RESET_IP);
            pipe_q     <= '0;
        end else begin
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            q_ip_q     <= q_ip_d;
            address_q  <= address_d;
            pipe_q     <= pipe_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .wr_en   (capture),
        .wr_data (i_data),
        .rd_en   (take_fire),
        .rd_data (q_byte),
        .count   (q_count),
        .valid   (q_valid)
    );

    assign address = address_q;
    assign rd      = pipe_q.rd;
    assign q_ip    = q_ip_q;

endmodule

// File: doc/x86_prefetch.md
Name: x86_prefetch

Overview:
- Instruction prefetch queue sitting directly upstream of the x86cpu decoder.
- Fetches code bytes from the shared 8-bit memory bus at cs:ip linear addresses while the bus is granted.
- Buffers the bytes in a small circular queue.
- Hands bytes one at a time to the opcode/prefix/modrm/imm parser through a valid/take handshake, with the IP of the head byte.
- Refills from a new cs:ip on flush (far/near jumps, interrupts, reset).

Parameters:
DEPTH, 8, queue capacity in bytes; power of two, 4..16.
RESET_CS, 16'hFFFF, code segment loaded by reset.
RESET_IP, 16'h0000, instruction pointer loaded by reset.

Ports:
clock  in  1  system clock, 12.5 MHz, all state on rising edge
reset_n  in  1  asynchronous active-low reset
locked  in  1  global run enable; low freezes new requests and consumption
flush  in  1  discard queue and in-flight byte, restart at new_cs:new_ip
new_cs  in  16  code segment for restart, sampled when flush=1
new_ip  in  16  instruction pointer for restart, sampled when flush=1
bus_grant  in  1  arbiter permits a code fetch this cycle
address  out  20  linear fetch address ({fetch_cs,4'h0}+fetch_ip) mod 2^20
rd  out  1  fetch request strobe, registered
i_data  in  8  memory read data, valid exactly one cycle after rd
q_byte  out  8  head byte of queue
q_valid  out  1  queue non-empty
q_take  in  1  decoder consumes head byte this cycle
q_ip  out  16  IP of head byte (IP of next byte when empty)
q_count  out  $clog2(DEPTH)+1  bytes currently held

Behaviour:
- Reset (async, reset_n=0):
  - rd=0, count=0, q_valid=0, inflight=0, drop=0.
  - fetch_cs=RESET_CS, fetch_ip=RESET_IP, q_ip=RESET_IP, address=20'hFFFF0 with defaults.
  - Reset mid-fetch loses the returning byte; it is not captured.
- Request issue (registered rd): rd<=1 when locked & bus_grant & !flush & (count+inflight_next < DEPTH). In the same edge, fetch_ip<=fetch_ip+1 and address is updated to the request address. Otherwise rd<=0.
- Only one request per cycle; latency is 1, so at most one byte is in flight (inflight = rd).
- Capture: in the cycle after rd=1, i_data is written at the tail unless drop=1. Capture happens regardless of locked or bus_grant, so no byte is ever lost by a bus steal or stall.
- Consume: if q_take & q_valid & locked, the head advances and q_ip<=q_ip+1. q_take while empty or while locked=0 is ignored.
- Simultaneous capture and take: count unchanged, both pointers advance. Full queue with take and capture in the same cycle is legal.
- Full: no request is issued while count+inflight reaches DEPTH; issue resumes the cycle after a take frees space.
- Flush has priority over take, capture and issue:
  - count<=0 and pointers reset.
  - fetch_cs<=new_cs; fetch_ip<=new_ip; q_ip<=new_ip.
  - drop<=rd, discarding the byte of any request already issued; rd<=0.
  - First request at the new address is issued no earlier than the cycle after flush.
- Flush while locked=0 is still honoured.
- Wrap-around:
  - fetch_ip and q_ip are 16-bit and wrap FFFF->0000 inside the segment; cs is unchanged.
  - Linear address wraps modulo 2^20 (FFFF:0010 -> 00000).
  - Queue pointers wrap modulo DEPTH.
- q_byte and q_valid are registered-array reads of the head entry and are valid in the same cycle as q_count>0.

Decomposition:
- Shared package x86_pkg:
  - DEPTH default, RESET_CS/RESET_IP constants.
  - Linear-address helper function {seg,4'h0}+off, shared with the decoder's address16 logic.
- One sub-module, prefetch_fifo: DEPTH x 8 circular buffer with wr/rd/clear, head/tail pointers and count.
- Fetch address/request logic, drop flag and IP tracking stay in x86_prefetch.

Test Plan:
- Release reset, bus_grant=1, no take -> rd pulses with address FFFF0..FFFF7 on consecutive cycles, q_count reaches 8 and holds, and rd stays 0 with no 9th request.
- Full queue, q_take=1 for one cycle -> q_ip 0000->0001, q_count 8->7, one new rd at FFFF8, q_count back to 8 two cycles later.
- flush with new_cs=0x0000, new_ip=0x7C00 in the cycle after an rd -> returning byte is dropped, q_valid=0, and the next rd addresses 07C00 with q_ip=7C00.
- Steady take every cycle with bus_grant toggling 1,0,1,0 -> bytes emerge in address order with no duplicates or gaps; q_byte equals the memory model contents at q_ip.
- fetch at cs=0x1000, ip=0xFFFE -> addresses 1FFFE, 1FFFF, then 10000 (ip wraps to 0000); q_ip likewise wraps FFFF->0000.
- reset_n asserted while count=5 and rd=1 -> q_valid=0 and rd=0 immediately (async); after release the first address is FFFF0.
